// File: rtl/alu_ctrl_queue_pkg.sv
// Shared constants and types for the ALU-control queue stage.
// Holds the TSC opcode/funct encodings, ALU function codes, branch types
// and the packed payload stored per FIFO entry.
package alu_ctrl_queue_pkg;

  // Width of the decoded function code before zero-extension to FUNC_W.
  localparam int unsigned FUNC_BASE_W = 4;

  // Instruction opcodes, instruction[15:12].
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type funct field, instruction[5:0].
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALU function codes presented to EX.
  localparam logic [FUNC_BASE_W-1:0] FUNC_ADD = 4'd0;
  localparam logic [FUNC_BASE_W-1:0] FUNC_SUB = 4'd1;
  localparam logic [FUNC_BASE_W-1:0] FUNC_AND = 4'd2;
  localparam logic [FUNC_BASE_W-1:0] FUNC_ORR = 4'd3;
  localparam logic [FUNC_BASE_W-1:0] FUNC_NOT = 4'd4;
  localparam logic [FUNC_BASE_W-1:0] FUNC_TCP = 4'd5;
  localparam logic [FUNC_BASE_W-1:0] FUNC_SHL = 4'd6;
  localparam logic [FUNC_BASE_W-1:0] FUNC_SHR = 4'd7;
  localparam logic [FUNC_BASE_W-1:0] FUNC_PSB = 4'd8;  // pass operand B (LHI/JAL/JPR/JRL)
  localparam logic [FUNC_BASE_W-1:0] FUNC_WWD = 4'd10;

  // Branch condition, equal to opcode[1:0] for branch opcodes.
  typedef enum logic [1:0] {
    BR_BNE = 2'd0,
    BR_BEQ = 2'd1,
    BR_BGZ = 2'd2,
    BR_BLZ = 2'd3
  } br_type_e;

  // Decoded payload held in each FIFO slot.
  typedef struct packed {
    logic [FUNC_BASE_W-1:0] func_code;
    br_type_e               branch_type;
    logic                   is_branch;
    logic                   illegal;
    logic                   is_hlt;
  } entry_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decoder.
// Ports: opcode_i/funct_i/alu_op_i in; func_code_c, branch_type_c,
// is_branch_c, illegal_c, is_hlt_c out (combinational).
module alu_ctrl_decode
  import alu_ctrl_queue_pkg::*;
(
  input  logic [3:0]             opcode_i,
  input  logic [5:0]             funct_i,
  input  logic                   alu_op_i,
  output logic [FUNC_BASE_W-1:0] func_code_c,
  output br_type_e               branch_type_c,
  output logic                   is_branch_c,
  output logic                   illegal_c,
  output logic                   is_hlt_c
);

  // Branch fields depend only on the opcode, never on alu_op.
  always_comb begin
    branch_type_c = br_type_e'(opcode_i[1:0]);
    is_branch_c   = (opcode_i < 4'd4);
  end

  // Function code; with alu_op low the ALU just increments the PC.
  always_comb begin
    func_code_c = FUNC_ADD;
    illegal_c   = 1'b0;
    is_hlt_c    = 1'b0;
    if (alu_op_i) begin
      case (opcode_i)
        OP_RTYPE: begin
          case (funct_i)
            FN_ADD:         func_code_c = FUNC_ADD;
            FN_SUB:         func_code_c = FUNC_SUB;
            FN_AND:         func_code_c = FUNC_AND;
            FN_ORR:         func_code_c = FUNC_ORR;
            FN_NOT:         func_code_c = FUNC_NOT;
            FN_TCP:         func_code_c = FUNC_TCP;
            FN_SHL:         func_code_c = FUNC_SHL;
            FN_SHR:         func_code_c = FUNC_SHR;
            FN_JPR, FN_JRL: func_code_c = FUNC_PSB;
            FN_WWD:         func_code_c = FUNC_WWD;
            FN_HLT:         is_hlt_c    = 1'b1;
            default:        illegal_c   = 1'b1;
          endcase
        end
        OP_ADI, OP_LWD, OP_SWD:         func_code_c = FUNC_ADD;
        OP_ORI:                         func_code_c = FUNC_ORR;
        OP_LHI, OP_JAL:                 func_code_c = FUNC_PSB;
        OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ,
        OP_JMP:                         func_code_c = FUNC_ADD;
        default:                        illegal_c   = 1'b1;  // opcodes 11..14
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_queue.sv
// ALU-control stage between ID and EX: decodes on enqueue and buffers the
// decoded result in a DEPTH-entry FIFO with valid/ready on both sides.
// Ports: clk, reset_n; upstream in_valid/in_ready/in_opcode/in_funct/
// in_alu_op/in_tag; flush; downstream out_valid/out_ready/out_func_code/
// out_branch_type/out_is_branch/out_illegal/out_tag; status count, halted.
module alu_ctrl_queue
  import alu_ctrl_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned FUNC_W = 4,
  parameter int unsigned TAG_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_opcode,
  input  logic [5:0]                   in_funct,
  input  logic                         in_alu_op,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FUNC_W-1:0]            out_func_code,
  output logic [1:0]                   out_branch_type,
  output logic                         out_is_branch,
  output logic                         out_illegal,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         halted
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Decoder for the incoming instruction.
  entry_t dec_entry;

  alu_ctrl_decode u_decode (
    .opcode_i      (in_opcode),
    .funct_i       (in_funct),
    .alu_op_i      (in_alu_op),
    .func_code_c   (dec_entry.func_code),
    .branch_type_c (dec_entry.branch_type),
    .is_branch_c   (dec_entry.is_branch),
    .illegal_c     (dec_entry.illegal),
    .is_hlt_c      (dec_entry.is_hlt)
  );

  entry_t             mem_q [DEPTH];
  logic [TAG_W-1:0]   tag_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               halt_pending_q, halt_pending_d;
  logic               halted_q, halted_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               push_c, pop_c, we_c;
  entry_t             head_c;

  assign push_c = in_valid && in_ready_q;
  assign pop_c  = out_valid_q && out_ready;
  assign we_c   = push_c && !flush;
  assign head_c = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and halt tracking; flush wins.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    halt_pending_d = halt_pending_q;
    halted_d       = halted_q;
    if (flush) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      halt_pending_d = 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (dec_entry.is_hlt) begin
          halt_pending_d = 1'b1;
        end
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (head_c.is_hlt) begin
          halted_d       = 1'b1;
          halt_pending_d = 1'b0;
        end
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // Handshake flags are registered from next-state so neither side sees
    // a combinational path from the other.
    in_ready_d  = (count_d != CNT_W'(DEPTH)) && !halt_pending_d && !halted_d;
    out_valid_d = (count_d != '0);
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      halt_pending_q <= 1'b0;
      halted_q       <= 1'b0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      halt_pending_q <= halt_pending_d;
      halted_q       <= halted_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
    end
  end

  // FIFO storage; written only on an accepted, non-flushed enqueue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (we_c) begin
      mem_q[wr_ptr_q] <= dec_entry;
      tag_q[wr_ptr_q] <= in_tag;
    end
  end

  // Head entry, forced to zero while the queue is empty.
  always_comb begin
    out_func_code   = '0;
    out_branch_type = '0;
    out_is_branch   = 1'b0;
    out_illegal     = 1'b0;
    out_tag         = '0;
    if (out_valid_q) begin
      out_func_code   = FUNC_W'(head_c.func_code);
      out_branch_type = head_c.branch_type;
      out_is_branch   = head_c.is_branch;
      out_illegal     = head_c.illegal;
      out_tag         = tag_q[rd_ptr_q];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_alu_ctrl_queue.sv
// Scoreboard bench for alu_ctrl_queue: the driver pushes hand-computed
// expected entries, a negedge monitor pops and compares on each transfer.
module tb_alu_ctrl_queue;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned TAG_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [5:0]        in_funct;
  logic              in_alu_op;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [FUNC_W-1:0] out_func_code;
  logic [1:0]        out_branch_type;
  logic              out_is_branch;
  logic              out_illegal;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        count;
  logic              halted;

  typedef struct {
    int unsigned func;
    int unsigned br;
    int unsigned isbr;
    int unsigned ill;
    int unsigned tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  alu_ctrl_queue #(.DEPTH(DEPTH), .FUNC_W(FUNC_W), .TAG_W(TAG_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_opcode       (in_opcode),
    .in_funct        (in_funct),
    .in_alu_op       (in_alu_op),
    .in_tag          (in_tag),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_func_code   (out_func_code),
    .out_branch_type (out_branch_type),
    .out_is_branch   (out_is_branch),
    .out_illegal     (out_illegal),
    .out_tag         (out_tag),
    .count           (count),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("func_code", 32'(out_func_code), e.func);
        chk("branch_type", 32'(out_branch_type), e.br);
        chk("is_branch", 32'(out_is_branch), e.isbr);
        chk("illegal", 32'(out_illegal), e.ill);
        chk("tag", 32'(out_tag), e.tag);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the request until accepted (bounded).
  task automatic send(input logic [3:0] op, input logic [5:0] fn, input logic aop,
                      input int unsigned tag, input int unsigned efunc,
                      input int unsigned ebr, input int unsigned eisbr,
                      input int unsigned eill);
    exp_t e;
    int   k;
    in_valid  = 1'b1;
    in_opcode = op;
    in_funct  = fn;
    in_alu_op = aop;
    in_tag    = TAG_W'(tag);
    k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    if (k == 50) begin
      chk("in_ready_timeout", 0, 1);
    end else begin
      e.func = efunc; e.br = ebr; e.isbr = eisbr; e.ill = eill; e.tag = tag;
      sb.push_back(e);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((out_valid || sb.size() != 0) && k < 50) begin
      step();
      k++;
    end
    chk("drain_timeout", 32'(k < 50), 1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct = '0;
    in_alu_op = 1'b0; in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    #23 reset_n = 1'b1;
    step();

    // Reset state.
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_func", 32'(out_func_code), 0);
    chk("rst_tag", 32'(out_tag), 0);

    // ADD: visible one edge after enqueue.
    send(4'd15, 6'd0, 1'b1, 32'h0010, 0, 3, 0, 0);
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_count", 32'(count), 1);
    chk("lat_func", 32'(out_func_code), 0);
    chk("lat_tag", 32'(out_tag), 32'h0010);
    chk("lat_illegal", 32'(out_illegal), 0);
    out_ready = 1'b1;
    drain();

    // ORI, LHI fill the queue; BGZ waits until out_ready opens it.
    out_ready = 1'b0;
    send(4'd5, 6'd0, 1'b1, 32'h0020, 3, 1, 0, 0);
    send(4'd6, 6'd0, 1'b1, 32'h0022, 8, 2, 0, 0);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), 2);
    fork
      send(4'd2, 6'd0, 1'b1, 32'h0024, 0, 2, 1, 0);
      begin
        step(); step();
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal decodes, alu_op=0, branch, and several R-type functs back to back.
    send(4'd15, 6'h3F, 1'b1, 32'h0030, 0, 3, 0, 1);
    send(4'd12, 6'd0,  1'b1, 32'h0032, 0, 0, 0, 1);
    send(4'd15, 6'd1,  1'b0, 32'h0034, 0, 3, 0, 0);
    send(4'd0,  6'd0,  1'b1, 32'h0036, 0, 0, 1, 0);
    send(4'd15, 6'd1,  1'b1, 32'h0038, 1, 3, 0, 0);
    send(4'd15, 6'd28, 1'b1, 32'h003A, 10, 3, 0, 0);
    send(4'd15, 6'd26, 1'b1, 32'h003C, 8, 3, 0, 0);
    send(4'd15, 6'd5,  1'b1, 32'h003E, 5, 3, 0, 0);
    send(4'd3,  6'd0,  1'b0, 32'h0040, 0, 3, 1, 0);
    drain();

    // Flush a full queue while enqueue and dequeue are both requested.
    out_ready = 1'b0;
    send(4'd4, 6'd0, 1'b1, 32'h0050, 0, 0, 0, 0);
    send(4'd8, 6'd0, 1'b1, 32'h0052, 0, 0, 0, 0);
    chk("preflush_count", 32'(count), 2);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_opcode = 4'd5; in_tag = 16'h0054;
    sb.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    step();
    chk("flush_nothing_accepted", 32'(count), 0);

    // HLT: closes input, sets halted on dequeue, survives flush.
    out_ready = 1'b0;
    send(4'd15, 6'd29, 1'b1, 32'h0060, 0, 3, 0, 0);
    chk("hlt_in_ready", 32'(in_ready), 0);
    chk("hlt_not_yet_halted", 32'(halted), 0);
    out_ready = 1'b1;
    step();
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_count", 32'(count), 0);
    chk("hlt_in_ready_after", 32'(in_ready), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("hlt_halted_after_flush", 32'(halted), 1);
    chk("hlt_in_ready_after_flush", 32'(in_ready), 0);

    // Asynchronous reset mid-cycle clears halted without an edge.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_halted", 32'(halted), 0);
    step();
    reset_n = 1'b1;
    step();
    chk("arst_in_ready", 32'(in_ready), 1);

    // Asynchronous reset with one entry queued.
    out_ready = 1'b0;
    send(4'd7, 6'd0, 1'b1, 32'h0070, 0, 3, 0, 0);
    chk("arst2_pre_count", 32'(count), 1);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("arst2_count", 32'(count), 0);
    chk("arst2_out_valid", 32'(out_valid), 0);
    chk("arst2_halted", 32'(halted), 0);
    step();
    reset_n = 1'b1;
    step();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
